// File: rtl/timer_display_pkg.sv
// Shared constants for the timer_display slice: active-low 7-segment
// patterns (bit order {g,f,e,d,c,b,a}), anode encodings and the digit-slot
// enumeration used by the scan counter.
package timer_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [3:0] AN_OFF = 4'hF;

  // Scan slot order: rightmost digit first.
  typedef enum logic [1:0] {
    IdxSecUnit = 2'd0,
    IdxSecTens = 2'd1,
    IdxMinUnit = 2'd2,
    IdxMinTens = 2'd3
  } digit_idx_e;

  // Active-low one-hot anode for a given slot.
  function automatic logic [3:0] an_for(input digit_idx_e idx);
    logic [3:0] an;
    an = AN_OFF;
    unique case (idx)
      IdxSecUnit: an = 4'b1110;
      IdxSecTens: an = 4'b1101;
      IdxMinUnit: an = 4'b1011;
      IdxMinTens: an = 4'b0111;
      default:    an = AN_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd_i  4-bit code; 0-9 decode to digits, 10-15 decode to a dash
//   seg_o  active-low segments {g,f,e,d,c,b,a}
module bcd_to_7seg
  import timer_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/timer_display.sv
// Time-multiplexed driver for a common-anode 4-digit 7-segment display
// showing MM:SS from the countdown timer. Digits are snapshotted once per
// scan frame, the minute-tens digit can be blanked when zero, the colon is
// lit on the minute-units slot, and the whole display blinks while
// `finished` is high. All outputs are registered.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_second_unit/tens BCD seconds digits
//   in_minute_unit/tens BCD minutes digits
//   finished            timer has reached 00:00 (enables blinking)
//   seg                 active-low segments {g,f,e,d,c,b,a}
//   an                  active-low one-hot anode select
//   dp                  active-low colon / decimal point
module timer_display
  import timer_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned BLINK_DIV = 8,
  parameter int unsigned BLANK_LZ  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_second_unit,
  input  logic [3:0] in_second_tens,
  input  logic [3:0] in_minute_unit,
  input  logic [3:0] in_minute_tens,
  input  logic       finished,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned ScanW  = $clog2(SCAN_DIV);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);

  logic [ScanW-1:0]  scan_cnt_q;
  digit_idx_e        idx_q;
  logic [3:0][3:0]   snap_q;      // indexed by digit_idx_e
  logic [BlinkW-1:0] blink_cnt_q;
  logic              blank_q;     // 1 = blank half of the blink period
  logic              tick;
  logic              blank_now;
  logic [3:0]        cur_digit;
  logic [6:0]        dec_seg;
  logic [6:0]        seg_d;
  logic [3:0]        an_d;
  logic              dp_d;

  assign tick      = (scan_cnt_q == ScanW'(SCAN_DIV - 1));
  assign cur_digit = snap_q[idx_q];
  // Dropping `finished` must unblank on the very next output update, so the
  // stale phase register is masked rather than waited on.
  assign blank_now = finished & blank_q;

  bcd_to_7seg u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  // Scan prescaler, digit index and per-frame snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q <= '0;
      idx_q      <= IdxSecUnit;
      snap_q     <= '0;
    end else begin
      if (tick) begin
        scan_cnt_q <= '0;
        idx_q      <= digit_idx_e'(idx_q + 2'd1);
        // Latch at the frame boundary so the next frame is coherent.
        if (idx_q == IdxMinTens) begin
          snap_q[IdxSecUnit] <= in_second_unit;
          snap_q[IdxSecTens] <= in_second_tens;
          snap_q[IdxMinUnit] <= in_minute_unit;
          snap_q[IdxMinTens] <= in_minute_tens;
        end
      end else begin
        scan_cnt_q <= scan_cnt_q + ScanW'(1);
      end
    end
  end

  // Blink timebase; runs only while finished, first phase is visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else if (!finished) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blank_q     <= ~blank_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BlinkW'(1);
    end
  end

  always_comb begin
    seg_d = dec_seg;
    an_d  = an_for(idx_q);
    dp_d  = (idx_q == IdxMinUnit) ? 1'b0 : 1'b1;
    if ((BLANK_LZ != 0) && (idx_q == IdxMinTens) && (cur_digit == 4'd0)) begin
      seg_d = SEG_BLANK;
    end
    if (blank_now) begin
      seg_d = SEG_BLANK;
      an_d  = AN_OFF;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
      dp  <= 1'b1;
    end else begin
      seg <= seg_d;
      an  <= an_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_timer_display.sv
// Randomized bench for timer_display. Two instances (leading-zero blanking
// on and off) share all inputs; every cycle both are compared against a
// cycle-count model: the slot shown after the n-th edge since reset release
// is ((n-1)/SCAN_DIV)%4, frames latch inputs on every 4*SCAN_DIV-th edge,
// and blink state is derived from how long `finished` has been high.
module tb_timer_display;

  localparam int S = 4;
  localparam int B = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] su, st, mu, mt;
  logic       finished;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       dp_a, dp_b;

  always #5 clk = ~clk;

  timer_display #(.SCAN_DIV(S), .BLINK_DIV(B), .BLANK_LZ(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_second_unit (su),
    .in_second_tens (st),
    .in_minute_unit (mu),
    .in_minute_tens (mt),
    .finished       (finished),
    .seg            (seg_a),
    .an             (an_a),
    .dp             (dp_a)
  );

  timer_display #(.SCAN_DIV(S), .BLINK_DIV(B), .BLANK_LZ(0)) dut_nolz (
    .clk            (clk),
    .rst            (rst),
    .in_second_unit (su),
    .in_second_tens (st),
    .in_minute_unit (mu),
    .in_minute_tens (mt),
    .finished       (finished),
    .seg            (seg_b),
    .an             (an_b),
    .dp             (dp_b)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state.
  int         n;          // edges since reset release
  int         k;          // consecutive edges with finished high
  logic [3:0] msnap [4];  // frame being displayed, slot order
  bit         m_blank;

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic void ref_out(input int slot, input logic [3:0] d, input bit lz,
                                  input bit blank, output logic [6:0] s,
                                  output logic [3:0] a, output logic p);
    a = 4'hF;
    if (blank) begin
      s = 7'h7F;
      p = 1'b1;
    end else begin
      a[slot] = 1'b0;
      s = (lz && slot == 3 && d == 4'd0) ? 7'h7F : ref_seg(d);
      p = (slot == 2) ? 1'b0 : 1'b1;
    end
  endfunction

  task automatic model_clear();
    n = 0;
    k = 0;
    m_blank = 1'b0;
    for (int i = 0; i < 4; i++) msnap[i] = 4'd0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_seg"}, seg_a, 7'h7F);
    check_eq({tag, "_an"}, {3'b000, an_a}, 7'h0F);
    check_eq({tag, "_dp"}, {6'b0, dp_a}, 7'h01);
    check_eq({tag, "_seg_nolz"}, seg_b, 7'h7F);
    check_eq({tag, "_an_nolz"}, {3'b000, an_b}, 7'h0F);
  endtask

  // One clock: predict from inputs stable across the edge, then compare.
  task automatic cycle();
    int         slot;
    logic [6:0] es1, es0;
    logic [3:0] ea1, ea0;
    logic       ep1, ep0;
    @(posedge clk);
    n++;
    if (finished) k++;
    else k = 0;
    m_blank = finished && (((k - 1) / B) % 2 == 1);
    slot = ((n - 1) / S) % 4;
    ref_out(slot, msnap[slot], 1'b1, m_blank, es1, ea1, ep1);
    ref_out(slot, msnap[slot], 1'b0, m_blank, es0, ea0, ep0);
    if (n % (4 * S) == 0) begin
      msnap[0] = su;
      msnap[1] = st;
      msnap[2] = mu;
      msnap[3] = mt;
    end
    #1;
    check_eq("seg", seg_a, es1);
    check_eq("an", {3'b000, an_a}, {3'b000, ea1});
    check_eq("dp", {6'b0, dp_a}, {6'b0, ep1});
    check_eq("seg_nolz", seg_b, es0);
    check_eq("an_nolz", {3'b000, an_b}, {3'b000, ea0});
    check_eq("dp_nolz", {6'b0, dp_b}, {6'b0, ep0});
  endtask

  task automatic rand_digits();
    su = 4'($urandom_range(0, 15));
    st = 4'($urandom_range(0, 15));
    mu = 4'($urandom_range(0, 15));
    mt = 4'($urandom_range(0, 15));
  endtask

  // Called just after a rising edge; asserts reset between edges.
  task automatic do_reset(input int cycles);
    #1 rst = 1'b0;
    #1 check_reset("rst_async");
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      rand_digits();
      #1 check_reset("rst_hold");
    end
    #1 rst = 1'b1;
    model_clear();
    #1 check_reset("rst_release");
  endtask

  task automatic set_time(input logic [3:0] m_t, input logic [3:0] m_u,
                          input logic [3:0] s_t, input logic [3:0] s_u);
    mt = m_t;
    mu = m_u;
    st = s_t;
    su = s_u;
  endtask

  initial begin
    int guard;
    finished = 1'b0;
    rand_digits();
    model_clear();

    // Power-on reset with an explicit falling edge.
    #2 rst = 1'b0;
    #1 check_reset("por");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      rand_digits();
      #1 check_reset("por_hold");
    end
    #1 rst = 1'b1;
    model_clear();
    #1 check_reset("por_release");

    // Static 12:34.
    set_time(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (3 * 4 * S) cycle();

    // 05:07: leading-zero blanking differs between the two instances.
    set_time(4'd0, 4'd5, 4'd0, 4'd7);
    repeat (3 * 4 * S) cycle();

    // Snapshot: change seconds units while slot 1 is on display.
    set_time(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (2 * 4 * S) cycle();
    guard = 0;
    while (((n / S) % 4) != 1 && guard < 64) begin
      cycle();
      guard++;
    end
    su = 4'd9;
    repeat (2 * 4 * S) cycle();
    su = 4'hC;
    repeat (2 * 4 * S) cycle();

    // Blink at 00:00, then drop finished during a blank phase.
    set_time(4'd0, 4'd0, 4'd0, 4'd0);
    finished = 1'b1;
    repeat (5 * B) cycle();
    guard = 0;
    while (!m_blank && guard < 4 * B) begin
      cycle();
      guard++;
    end
    check_eq("blank_reached", {6'b0, m_blank}, 7'h01);
    finished = 1'b0;
    cycle();
    repeat (4 * S) cycle();

    // Mid-scan reset while slot 2 is selected.
    set_time(4'd1, 4'd2, 4'd3, 4'd4);
    guard = 0;
    while (((n / S) % 4) != 2 && guard < 64) begin
      cycle();
      guard++;
    end
    do_reset(3);
    repeat (2 * 4 * S) cycle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) su = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) st = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) mu = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) mt = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) finished = ~finished;
      if ($urandom_range(0, 399) == 0) do_reset(int'($urandom_range(1, 3)));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_display.md
Name: timer_display

Overview:
- Downstream consumer of the countdown timer.
- Takes the four BCD digits (MM:SS) and the `finished` flag, and drives a common-anode 4-digit 7-segment display by time-multiplexing.
- Provides leading-zero blanking on the minute-tens digit, a steady colon, and full-display blinking while `finished` is high.
- All outputs are registered. Digits are snapshotted once per scan frame so a frame never shows a mix of old and new values.

Parameters:
- SCAN_DIV, 4, clock cycles per digit slot (scan tick period); must be ≥2.
- BLINK_DIV, 8, clock cycles per blink half-period while finished=1; must be ≥2.
- BLANK_LZ, 1, 1 = blank minute-tens digit when it is 0.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- in_second_unit  input  4  BCD seconds units from timer
- in_second_tens  input  4  BCD seconds tens
- in_minute_unit  input  4  BCD minutes units
- in_minute_tens  input  4  BCD minutes tens
- finished  input  1  timer reached 00:00
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- an  output  4  digit anode select, active-low, one-hot
- dp  output  1  decimal point/colon, active-low

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst=0 resets immediately, independent of clk).
- Reset values:
  - seg=7'h7F, an=4'hF, dp=1
  - scan counter=0, digit index idx=0, blink counter=0, blink phase=visible
  - all snapshot digits=0
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - `tick` is asserted in the cycle where the count equals SCAN_DIV-1.
- Digit index:
  - On tick, idx increments 0→1→2→3→0.
  - Mapping: idx0 = second_unit (an=1110), idx1 = second_tens (1101), idx2 = minute_unit (1011), idx3 = minute_tens (0111).
- Snapshot:
  - On a tick with idx=3, all four input digits are latched into the snapshot register.
  - That snapshot is shown during the next frame (idx 0..3).
  - Input changes at other times have no effect until the next frame boundary.
  - Latency from an input change to display is therefore up to 2 frames (8·SCAN_DIV cycles).
- Output register:
  - seg, an and dp are registered from the current idx and snapshot.
  - Outputs reflect a new idx one clock after idx updates.
- Decode: 0-9 use standard patterns. Codes 10-15 show a dash (seg=7'b0111111).
- Leading-zero blanking: when BLANK_LZ=1, idx=3 and snapshot minute_tens=0, seg=7'h7F. an still selects the digit.
- Colon: dp=0 when idx=2, otherwise 1.
- Blink:
  - While finished=1, the blink counter counts 0..BLINK_DIV-1 and toggles the phase at wrap.
  - In the blank phase, an=4'hF and dp=1 (seg don't-care; drive 7'h7F).
  - The first phase after finished rises is visible.
  - When finished=0, the blink counter clears to 0 and the phase is forced visible in the same cycle.
- Scan during blink: scan and snapshot continue running during blink, so the phase never stalls scanning.
- Reset mid-operation: all state returns to reset values asynchronously. The scan restarts at idx0 after release.

Decomposition:
- Package timer_display_pkg:
  - localparams SEG_BLANK=7'h7F, SEG_DASH=7'b0111111, the 10 digit patterns, AN_OFF=4'hF.
  - Digit-index encodings.
- Sub-module bcd_to_7seg: purely combinational, 4-bit in, 7-bit active-low out, dash for >9.
- The top module holds the counters, snapshot, blink logic and output registers.

Test Plan:
- Reset: hold rst=0 with random inputs → seg=7F, an=F, dp=1. Release rst → first an=1110 appears 1 cycle after release; each slot lasts 4 cycles.
- Static 12:34 (m_t=1, m_u=2, s_t=3, s_u=4), finished=0, after one full frame:
  - an=1110 / seg=0011001 (4)
  - an=1101 / seg=0110000 (3)
  - an=1011 / seg=0100100 (2), dp=0
  - an=0111 / seg=1111001 (1)
- 05:07 with BLANK_LZ=1 → the idx3 slot shows seg=7F. Repeat with BLANK_LZ=0 → seg=1000000.
- Snapshot: change s_u 4→9 while idx=1 → the current frame still shows 4; the next frame shows 9 (seg=0010000). Value 4'hC → dash 0111111.
- Blink: assert finished with 00:00 → 8 cycles of normal scan, then 8 cycles with an=F and dp=1, repeating. Drop finished during the blank phase → the next clock shows a visible anode.
- Mid-scan reset: pulse rst low for 3 cycles while idx=2 → outputs go to reset values immediately, with no clk edge needed; scan resumes at idx0.
